// File: rtl/systolic_feeder.sv
// Front-end for the systolic array: collects a weight tile, replays it into the array
// last-row-first, then streams data vectors with a per-lane diagonal skew.
module systolic_feeder #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DATA_SIZE-1:0]   w_row [MATRIX_SIZE],
    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic [DATA_SIZE-1:0]   d_vec [MATRIX_SIZE],
    input  logic                   d_last,
    output logic [DATA_SIZE-1:0]   out_weights [MATRIX_SIZE],
    output logic [MATRIX_SIZE-1:0] out_load_weight,
    output logic [DATA_SIZE-1:0]   out_data [MATRIX_SIZE],
    output logic [MATRIX_SIZE-1:0] out_enable_mult,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_COLLECT = 3'd1;
    localparam logic [2:0] W_LOAD    = 3'd2;
    localparam logic [2:0] D_STREAM  = 3'd3;
    localparam logic [2:0] D_DRAIN   = 3'd4;

    logic [2:0]             state;
    logic [IDX_W-1:0]       cnt;
    logic [IDX_W-1:0]       rd_idx;
    logic [DATA_SIZE-1:0]   w_buf [MATRIX_SIZE][MATRIX_SIZE];
    logic                   w_accept;
    logic                   d_accept;
    logic [DATA_SIZE-1:0]   lane_in  [MATRIX_SIZE];
    logic [DATA_SIZE-1:0]   tap_data [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] tap_vld;

    // Handshake readies are held low while reset is asserted so every output reads 0.
    assign w_ready  = reset && ((state == IDLE) || (state == W_COLLECT));
    assign d_ready  = reset && (state == D_STREAM);
    assign busy     = (state != IDLE);
    assign w_accept = w_valid && w_ready;
    assign d_accept = d_valid && d_ready;
    assign rd_idx   = LAST_IDX - cnt - IDX_W'(1);

    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            lane_in[i] = d_accept ? d_vec[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            done            <= 1'b0;
            out_load_weight <= '0;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                out_weights[r] <= '0;
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    w_buf[r][j] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, W_COLLECT: begin
                    if (w_accept) begin
                        for (int j = 0; j < MATRIX_SIZE; j++) begin
                            w_buf[cnt][j] <= w_row[j];
                        end
                        // The final row bypasses the buffer so W_LOAD can present it on its first cycle.
                        if (cnt == LAST_IDX) begin
                            state           <= W_LOAD;
                            cnt             <= '0;
                            out_load_weight <= '1;
                            for (int j = 0; j < MATRIX_SIZE; j++) begin
                                out_weights[j] <= w_row[j];
                            end
                        end else begin
                            state <= W_COLLECT;
                            cnt   <= cnt + IDX_W'(1);
                        end
                    end
                end
                W_LOAD: begin
                    if (cnt == LAST_IDX) begin
                        state           <= D_STREAM;
                        cnt             <= '0;
                        out_load_weight <= '0;
                        for (int j = 0; j < MATRIX_SIZE; j++) begin
                            out_weights[j] <= '0;
                        end
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                        for (int j = 0; j < MATRIX_SIZE; j++) begin
                            out_weights[j] <= w_buf[rd_idx][j];
                        end
                    end
                end
                D_STREAM: begin
                    if (d_accept && d_last) begin
                        state <= D_DRAIN;
                        cnt   <= '0;
                    end
                end
                D_DRAIN: begin
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Lane i gets i delay stages ahead of the shared output register.
    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign tap_data[i] = lane_in[i];
            assign tap_vld[i]  = d_accept;
        end else begin : g_skew
            logic [DATA_SIZE-1:0] sk_data [i];
            logic [i-1:0]         sk_vld;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sk_vld <= '0;
                    for (int s = 0; s < i; s++) begin
                        sk_data[s] <= '0;
                    end
                end else begin
                    sk_data[0] <= lane_in[i];
                    sk_vld[0]  <= d_accept;
                    for (int s = 1; s < i; s++) begin
                        sk_data[s] <= sk_data[s-1];
                        sk_vld[s]  <= sk_vld[s-1];
                    end
                end
            end

            assign tap_data[i] = sk_data[i-1];
            assign tap_vld[i]  = sk_vld[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_enable_mult <= '0;
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                out_data[i] <= '0;
            end
        end else begin
            out_enable_mult <= tap_vld;
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                out_data[i] <= tap_data[i];
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=2): table of per-cycle vectors with
// hand-computed expectations, plus a mid-tile asynchronous reset sequence.
module tb_systolic_feeder;

    localparam int N = 2;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         w_valid;
    logic         w_ready;
    logic [W-1:0] w_row [N];
    logic         d_valid;
    logic         d_ready;
    logic [W-1:0] d_vec [N];
    logic         d_last;
    logic [W-1:0] out_weights [N];
    logic [N-1:0] out_load_weight;
    logic [W-1:0] out_data [N];
    logic [N-1:0] out_enable_mult;
    logic         busy;
    logic         done;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic                 w_valid;
        logic [N-1:0][W-1:0]  w_row;
        logic                 d_valid;
        logic [N-1:0][W-1:0]  d_vec;
        logic                 d_last;
        logic                 exp_w_ready;
        logic                 exp_d_ready;
        logic                 exp_busy;
        logic [N-1:0]         exp_load;
        logic [N-1:0][W-1:0]  exp_weights;
        logic [N-1:0]         exp_en;
        logic [N-1:0][W-1:0]  exp_data;
        logic                 exp_done;
    } vec_t;

    vec_t tbl[$];

    systolic_feeder #(.MATRIX_SIZE(N), .DATA_SIZE(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_row           (w_row),
        .d_valid         (d_valid),
        .d_ready         (d_ready),
        .d_vec           (d_vec),
        .d_last          (d_last),
        .out_weights     (out_weights),
        .out_load_weight (out_load_weight),
        .out_data        (out_data),
        .out_enable_mult (out_enable_mult),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic wv, input int w0, input int w1,
        input logic dv, input int d0, input int d1, input logic dl,
        input logic e_wr, input logic e_dr, input logic e_busy, input int e_load,
        input int e_w0, input int e_w1, input int e_en, input int e_d0, input int e_d1,
        input logic e_done);
        vec_t v;
        v.w_valid        = wv;
        v.w_row[0]       = W'(w0);
        v.w_row[1]       = W'(w1);
        v.d_valid        = dv;
        v.d_vec[0]       = W'(d0);
        v.d_vec[1]       = W'(d1);
        v.d_last         = dl;
        v.exp_w_ready    = e_wr;
        v.exp_d_ready    = e_dr;
        v.exp_busy       = e_busy;
        v.exp_load       = N'(e_load);
        v.exp_weights[0] = W'(e_w0);
        v.exp_weights[1] = W'(e_w1);
        v.exp_en         = N'(e_en);
        v.exp_data[0]    = W'(e_d0);
        v.exp_data[1]    = W'(e_d1);
        v.exp_done       = e_done;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        w_valid = 1'b0;
        d_valid = 1'b0;
        d_last  = 1'b0;
        for (int j = 0; j < N; j++) begin
            w_row[j] = '0;
            d_vec[j] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input vec_t v);
        check_val({tag, ".w_ready"}, W'(w_ready), W'(v.exp_w_ready));
        check_val({tag, ".d_ready"}, W'(d_ready), W'(v.exp_d_ready));
        check_val({tag, ".busy"},    W'(busy),    W'(v.exp_busy));
        check_val({tag, ".load"},    W'(out_load_weight), W'(v.exp_load));
        check_val({tag, ".wgt0"},    out_weights[0], v.exp_weights[0]);
        check_val({tag, ".wgt1"},    out_weights[1], v.exp_weights[1]);
        check_val({tag, ".en"},      W'(out_enable_mult), W'(v.exp_en));
        check_val({tag, ".data0"},   out_data[0], v.exp_data[0]);
        check_val({tag, ".data1"},   out_data[1], v.exp_data[1]);
        check_val({tag, ".done"},    W'(done), W'(v.exp_done));
    endtask

    // Inputs are applied just after an edge; expectations are the state seen just after the next edge.
    task automatic apply_stimulus(input string tag, input vec_t v);
        w_valid = v.w_valid;
        d_valid = v.d_valid;
        d_last  = v.d_last;
        for (int j = 0; j < N; j++) begin
            w_row[j] = v.w_row[j];
            d_vec[j] = v.d_vec[j];
        end
        step();
        check_output(tag, v);
    endtask

    initial begin
        vec_t in_reset;
        vec_t idle;
        in_reset = mk(0,0,0, 0,0,0,0, 0,0,0, 0, 0,0, 0, 0,0, 0);
        idle     = mk(0,0,0, 0,0,0,0, 1,0,0, 0, 0,0, 0, 0,0, 0);

        // Tile 1: collect, ignored simultaneous/late valids, stream with bubble, drain.
        tbl.push_back(mk(1,1,2,     0,0,0,0,     1,0,1, 0, 0,0,     0, 0,0,   0));
        tbl.push_back(mk(1,3,4,     1,99,99,0,   0,0,1, 3, 3,4,     0, 0,0,   0));
        tbl.push_back(mk(1,5,6,     1,77,77,0,   0,0,1, 3, 1,2,     0, 0,0,   0));
        tbl.push_back(mk(0,0,0,     1,88,88,0,   0,1,1, 0, 0,0,     0, 0,0,   0));
        tbl.push_back(mk(1,7,8,     1,10,20,0,   0,1,1, 0, 0,0,     1, 10,0,  0));
        tbl.push_back(mk(0,0,0,     0,0,0,1,     0,1,1, 0, 0,0,     2, 0,20,  0));
        tbl.push_back(mk(0,0,0,     1,30,40,0,   0,1,1, 0, 0,0,     1, 30,0,  0));
        tbl.push_back(mk(0,0,0,     1,50,60,1,   0,0,1, 0, 0,0,     3, 50,40, 0));
        tbl.push_back(mk(0,0,0,     1,11,12,0,   0,0,1, 0, 0,0,     2, 0,60,  0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     1,0,0, 0, 0,0,     0, 0,0,   1));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     1,0,0, 0, 0,0,     0, 0,0,   0));
        // Tile 2: stall during collect, overwrite of the weight buffer, back-to-back stream.
        tbl.push_back(mk(1,100,200, 0,0,0,0,     1,0,1, 0, 0,0,     0, 0,0,   0));
        tbl.push_back(mk(0,55,55,   0,0,0,0,     1,0,1, 0, 0,0,     0, 0,0,   0));
        tbl.push_back(mk(1,300,400, 0,0,0,0,     0,0,1, 3, 300,400, 0, 0,0,   0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,1, 3, 100,200, 0, 0,0,   0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     0,1,1, 0, 0,0,     0, 0,0,   0));
        tbl.push_back(mk(0,0,0,     1,10,20,0,   0,1,1, 0, 0,0,     1, 10,0,  0));
        tbl.push_back(mk(0,0,0,     1,30,40,1,   0,0,1, 0, 0,0,     3, 30,20, 0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     0,0,1, 0, 0,0,     2, 0,40,  0));
        tbl.push_back(mk(0,0,0,     0,0,0,0,     1,0,0, 0, 0,0,     0, 0,0,   1));

        reset = 1'b0;
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            step();
            check_output($sformatf("rst%0d", c), in_reset);
        end
        reset = 1'b1;
        #1;
        check_output("idle", idle);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus($sformatf("v%0d", i), tbl[i]);
        end

        // Mid-tile reset while lane 1 still holds 20 in its skew stage.
        apply_stimulus("m0", mk(1,5,6, 0,0,0,0, 1,0,1, 0, 0,0, 0, 0,0, 0));
        apply_stimulus("m1", mk(1,7,8, 0,0,0,0, 0,0,1, 3, 7,8, 0, 0,0, 0));
        apply_stimulus("m2", mk(0,0,0, 0,0,0,0, 0,0,1, 3, 5,6, 0, 0,0, 0));
        apply_stimulus("m3", mk(0,0,0, 0,0,0,0, 0,1,1, 0, 0,0, 0, 0,0, 0));
        apply_stimulus("m4", mk(0,0,0, 1,10,20,0, 0,1,1, 0, 0,0, 1, 10,0, 0));
        drive_idle();
        #2;
        reset = 1'b0;
        #1;
        check_output("mrst_async", in_reset);
        step();
        check_output("mrst_hold", in_reset);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check_output($sformatf("mpost%0d", c), idle);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
